rank_stim_driver: RTL and testbench

RANK_STIM_DRIVER -- requirements
Module: rank_stim_driver

---
 rtl/rank_stim_driver.sv | 146 ++++++++++++++
 tb/tb_rank_stim_driver.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rank_stim_driver.sv
// rank_stim_driver: replays ALU vectors from a vector memory into a ranking core and checks its third-largest result.
// Define RANK_DRV_TIMEOUT_EN to enable the WAIT-state watchdog (TIMEOUT_CYCLES); otherwise timeout is held at 0.
module rank_stim_driver #(
  parameter int ADDR_W         = 8,
  parameter int GAP            = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [7:0]        cfg_count,
  input  logic [7:0]        expected,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [19:0]       vec_data,
  output logic              start,
  output logic [7:0]        count,
  output logic              valid,
  output logic [7:0]        data_A,
  output logic [7:0]        data_B,
  output logic [3:0]        instruction,
  input  logic              finish,
  input  logic [7:0]        third_largest,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        result,
  output logic              timeout
);

`ifdef RANK_DRV_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  localparam logic [3:0]  GAP_N   = 4'(GAP);
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    SEND   = 3'd2,
    GAPW   = 3'd3,
    WAIT   = 3'd4,
    REPORT = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt_lat, exp_lat, sent;
  logic [3:0]  gap_cnt;
  logic [15:0] wd_cnt;
  logic        wd_fire, timeout_q, accept;

  assign accept  = (state == IDLE) && go;
  assign wd_fire = WD_EN && (wd_cnt == WD_LAST);
  assign timeout = timeout_q & WD_EN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = START;
      START:   state_nxt = (cnt_lat == 8'd0) ? WAIT : SEND;
      SEND: begin
        if (sent == cnt_lat)     state_nxt = WAIT;
        else if (GAP_N != 4'd0)  state_nxt = GAPW;
        else                     state_nxt = SEND;
      end
      GAPW:    if (gap_cnt == GAP_N) state_nxt = SEND;
      WAIT:    if (finish || wd_fire) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are loaded on the edge that enters the state they belong to,
  // so every output is a flop and the first beat lands the cycle after start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start       <= 1'b0;
      count       <= '0;
      valid       <= 1'b0;
      data_A      <= '0;
      data_B      <= '0;
      instruction <= '0;
      vec_addr    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      result      <= '0;
      timeout_q   <= 1'b0;
      cnt_lat     <= '0;
      exp_lat     <= '0;
      sent        <= '0;
      gap_cnt     <= '0;
      wd_cnt      <= '0;
    end else begin
      start <= (state_nxt == START);
      valid <= (state_nxt == SEND);
      done  <= (state_nxt == REPORT);

      if (accept) begin
        cnt_lat   <= cfg_count;
        exp_lat   <= expected;
        count     <= cfg_count;
        vec_addr  <= '0;
        sent      <= '0;
        timeout_q <= 1'b0;
        busy      <= 1'b1;
        pass      <= 1'b0;
        result    <= '0;
      end

      if (state_nxt == SEND) begin
        data_A      <= vec_data[19:12];
        data_B      <= vec_data[11:4];
        instruction <= vec_data[3:0];
        vec_addr    <= vec_addr + ADDR_W'(1);
        sent        <= sent + 8'd1;
      end

      if (state_nxt == GAPW)
        gap_cnt <= (state == GAPW) ? gap_cnt + 4'd1 : 4'd1;

      if (state_nxt == WAIT)
        wd_cnt <= (state == WAIT) ? wd_cnt + 16'd1 : '0;

      // Finish wins over an expiring watchdog in the same cycle.
      if (state == WAIT && state_nxt == REPORT) begin
        busy <= 1'b0;
        if (finish) begin
          result <= third_largest;
          pass   <= (third_largest == exp_lat);
        end else begin
          timeout_q <= 1'b1;
          result    <= '0;
          pass      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rank_stim_driver.sv
// Directed bench for rank_stim_driver: a GAP=0 instance with a small ranking-core model and a GAP=2, ADDR_W=2 instance.
module tb_rank_stim_driver;

  logic        clk = 1'b0, rst = 1'b0, go = 1'b0;
  logic [7:0]  cfg_count = 8'd0, expected = 8'd0;
  logic [7:0]  vec_addr, count, data_A, data_B, result, third_largest;
  logic [19:0] vec_data;
  logic [3:0]  instruction;
  logic        start, valid, finish, busy, done, pass, timeout;

  logic        go_g = 1'b0, finish_g = 1'b0;
  logic [7:0]  cfg_count_g = 8'd0, expected_g = 8'd0, tl_g = 8'd0;
  logic [1:0]  vec_addr_g;
  logic [19:0] vec_data_g;
  logic [7:0]  count_g, data_A_g, data_B_g, result_g;
  logic [3:0]  instruction_g;
  logic        start_g, valid_g, busy_g, done_g, pass_g, timeout_g;

  logic [19:0] mem   [0:255];
  logic [19:0] mem_g [0:3];
  assign vec_data   = mem[vec_addr];
  assign vec_data_g = mem_g[vec_addr_g];

  logic        core_en = 1'b1, finish_man = 1'b0, finish_m = 1'b0;
  logic [7:0]  tl_man = 8'd0;
  int          man_fin_at = -1;
  logic [7:0]  c_cnt = 8'd0, c_seen = 8'd0, t1 = 8'd0, t2 = 8'd0, t3 = 8'd0;
  logic [2:0]  c_delay = 3'd0;
  assign finish        = core_en ? finish_m : finish_man;
  assign third_largest = core_en ? t3 : tl_man;

  int n_checks = 0, n_fail = 0;

  logic [49:0] outs_main;
  logic [43:0] outs_g;
  assign outs_main = {start, count, valid, data_A, data_B, instruction, vec_addr, busy, done, pass, result, timeout};
  assign outs_g    = {start_g, count_g, valid_g, data_A_g, data_B_g, instruction_g, vec_addr_g, busy_g, done_g,
                      pass_g, result_g, timeout_g};

  rank_stim_driver #(.ADDR_W(8), .GAP(0), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .go(go), .cfg_count(cfg_count), .expected(expected),
    .vec_addr(vec_addr), .vec_data(vec_data), .start(start), .count(count), .valid(valid),
    .data_A(data_A), .data_B(data_B), .instruction(instruction), .finish(finish),
    .third_largest(third_largest), .busy(busy), .done(done), .pass(pass), .result(result),
    .timeout(timeout));

  rank_stim_driver #(.ADDR_W(2), .GAP(2), .TIMEOUT_CYCLES(64)) dut_g (
    .clk(clk), .rst(rst), .go(go_g), .cfg_count(cfg_count_g), .expected(expected_g),
    .vec_addr(vec_addr_g), .vec_data(vec_data_g), .start(start_g), .count(count_g), .valid(valid_g),
    .data_A(data_A_g), .data_B(data_B_g), .instruction(instruction_g), .finish(finish_g),
    .third_largest(tl_g), .busy(busy_g), .done(done_g), .pass(pass_g), .result(result_g),
    .timeout(timeout_g));

  always #5 clk = ~clk;

  // Ranking-core model: ADD results, tracks top three, raises finish a few cycles after the last beat.
  always @(posedge clk) begin : core_model
    logic [7:0] s;
    finish_m <= 1'b0;
    if (start) begin
      c_cnt <= count; c_seen <= 8'd0; c_delay <= 3'd0;
      t1 <= 8'd0; t2 <= 8'd0; t3 <= 8'd0;
    end else if (valid) begin
      s = data_A + data_B;
      if (s > t1)      begin t1 <= s; t2 <= t1; t3 <= t2; end
      else if (s > t2) begin t2 <= s; t3 <= t2; end
      else if (s > t3) t3 <= s;
      c_seen <= c_seen + 8'd1;
      if (c_seen + 8'd1 == c_cnt) c_delay <= 3'd3;
    end else if (c_delay != 3'd0) begin
      c_delay <= c_delay - 3'd1;
      if (c_delay == 3'd1) finish_m <= 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation still running, required finished");
    $fatal(1, "time limit");
  end

  task automatic run_main(input logic [7:0] n, input logic [7:0] e, input int go_busy_at, input bit go_at_report,
                          output int starts, output int beats, output int first_c, output bit contig,
                          output bit data_ok, output int dones, output int t_done,
                          output logic [7:0] res, output logic ps, output logic bz);
    int last_c;
    starts = 0; beats = 0; first_c = -1; last_c = -1; data_ok = 1'b1; dones = 0; t_done = -1;
    res = 8'hxx; ps = 1'bx; bz = 1'bx;
    go = 1'b1; cfg_count = n; expected = e;
    @(negedge clk);
    go = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (go_busy_at >= 0 && c == go_busy_at) begin go = 1'b1; cfg_count = 8'd9; expected = 8'd0; end
      else if (go_busy_at >= 0 && c == go_busy_at + 1) go = 1'b0;
      finish_man = !core_en && (c == man_fin_at);
      if (start) starts++;
      if (valid) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        if ({data_A, data_B, instruction} !== mem[beats]) data_ok = 1'b0;
        beats++;
      end
      if (done) begin
        dones++;
        if (t_done < 0) begin
          t_done = c; res = result; ps = pass; bz = busy;
          if (go_at_report) go = 1'b1;
        end
      end
      if (t_done >= 0 && c >= t_done + 1) break;
      @(negedge clk);
    end
    go = 1'b0; finish_man = 1'b0;
    contig = (beats == 0) || (last_c - first_c + 1 == beats);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #2 rst = 1'b1;
    #2;
    n_checks++;
    if (outs_main !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", outs_main); end
    n_checks++;
    if (outs_g !== '0) begin n_fail++; $display("FAIL reset_outputs_gap: got %h want 0", outs_g); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int st, bt, fc, dn, td; bit ct, dok; logic [7:0] rs; logic ps, bz;
    run_main(8'd5, 8'd30, -1, 1'b0, st, bt, fc, ct, dok, dn, td, rs, ps, bz);
    n_checks++; if (st != 1) begin n_fail++; $display("FAIL basic_start_cycles: got %0d want 1", st); end
    n_checks++; if (bt != 5) begin n_fail++; $display("FAIL basic_beats: got %0d want 5", bt); end
    n_checks++; if (fc != 1) begin n_fail++; $display("FAIL basic_first_beat: got cycle %0d want 1", fc); end
    n_checks++; if (!ct) begin n_fail++; $display("FAIL basic_contiguous: got %0d want 1", ct); end
    n_checks++; if (!dok) begin n_fail++; $display("FAIL basic_beat_data: got %0d want 1", dok); end
    n_checks++; if (dn != 1) begin n_fail++; $display("FAIL basic_done_cycles: got %0d want 1", dn); end
    n_checks++; if (td < 0 || td > 11) begin n_fail++; $display("FAIL basic_latency: got %0d want <=11", td); end
    n_checks++; if (rs !== 8'd30) begin n_fail++; $display("FAIL basic_result: got %0d want 30", rs); end
    n_checks++; if (ps !== 1'b1) begin n_fail++; $display("FAIL basic_pass: got %b want 1", ps); end
    n_checks++; if (bz !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b want 0", bz); end
    n_checks++;
    if ({count, vec_addr, valid, data_A, data_B, pass, result} !== {8'd5, 8'd5, 1'b0, 8'd20, 8'd30, 1'b1, 8'd30}) begin
      n_fail++;
      $display("FAIL basic_hold: got cnt=%0d addr=%0d v=%b A=%0d B=%0d p=%b r=%0d want 5 5 0 20 30 1 30",
               count, vec_addr, valid, data_A, data_B, pass, result);
    end
  endtask

  task automatic test_mismatch;
    int st, bt, fc, dn, td; bit ct, dok; logic [7:0] rs; logic ps, bz;
    run_main(8'd5, 8'd31, -1, 1'b0, st, bt, fc, ct, dok, dn, td, rs, ps, bz);
    n_checks++; if (rs !== 8'd30) begin n_fail++; $display("FAIL mismatch_result: got %0d want 30", rs); end
    n_checks++; if (ps !== 1'b0) begin n_fail++; $display("FAIL mismatch_pass: got %b want 0", ps); end
    n_checks++; if (dn != 1) begin n_fail++; $display("FAIL mismatch_done_cycles: got %0d want 1", dn); end
  endtask

  task automatic test_zero_count;
    int st, bt, fc, dn, td; bit ct, dok; logic [7:0] rs; logic ps, bz;
    core_en = 1'b0; tl_man = 8'h5A; man_fin_at = 3;
    run_main(8'd0, 8'h5A, -1, 1'b0, st, bt, fc, ct, dok, dn, td, rs, ps, bz);
    n_checks++; if (st != 1) begin n_fail++; $display("FAIL zero_start_cycles: got %0d want 1", st); end
    n_checks++; if (bt != 0) begin n_fail++; $display("FAIL zero_beats: got %0d want 0", bt); end
    n_checks++; if (td != 4) begin n_fail++; $display("FAIL zero_done_cycle: got %0d want 4", td); end
    n_checks++; if (rs !== 8'h5A || ps !== 1'b1) begin n_fail++; $display("FAIL zero_result: got %h/%b want 5a/1", rs, ps); end
    n_checks++; if (vec_addr !== 8'd0) begin n_fail++; $display("FAIL zero_addr: got %0d want 0", vec_addr); end
    core_en = 1'b1; man_fin_at = -1;
  endtask

  task automatic test_gap;
    logic [7:0] pat; bit dok; int nb;
    go_g = 1'b1; cfg_count_g = 8'd3;
    @(negedge clk);
    go_g = 1'b0;
    n_checks++; if (start_g !== 1'b1 || count_g !== 8'd3) begin n_fail++; $display("FAIL gap_start: got %b/%0d want 1/3", start_g, count_g); end
    pat = '0; dok = 1'b1; nb = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      pat = {pat[6:0], valid_g};
      if (valid_g) begin
        if ({data_A_g, data_B_g, instruction_g} !== mem_g[nb]) dok = 1'b0;
        nb++;
      end
    end
    n_checks++; if (pat !== 8'b1001_0010) begin n_fail++; $display("FAIL gap_valid_pattern: got %b want 10010010", pat); end
    n_checks++; if (!dok) begin n_fail++; $display("FAIL gap_beat_data: got %0d want 1", dok); end
    n_checks++; if (vec_addr_g !== 2'd3) begin n_fail++; $display("FAIL gap_addr_frozen: got %0d want 3", vec_addr_g); end
    finish_g = 1'b1;
    @(negedge clk);
    finish_g = 1'b0;
    n_checks++; if (done_g !== 1'b1) begin n_fail++; $display("FAIL gap_done: got %b want 1", done_g); end
    @(negedge clk);
    // Five beats through a four-entry memory: addresses 0,1,2,3,0.
    go_g = 1'b1; cfg_count_g = 8'd5;
    @(negedge clk);
    go_g = 1'b0; dok = 1'b1; nb = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (valid_g) begin
        if ({data_A_g, data_B_g, instruction_g} !== mem_g[nb % 4]) dok = 1'b0;
        nb++;
      end
    end
    n_checks++; if (nb != 5 || !dok) begin n_fail++; $display("FAIL wrap_beats: got %0d/%0d want 5/1", nb, dok); end
    n_checks++; if (vec_addr_g !== 2'd1) begin n_fail++; $display("FAIL wrap_addr: got %0d want 1", vec_addr_g); end
    finish_g = 1'b1;
    @(negedge clk);
    finish_g = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_go_ignored;
    int st, bt, fc, dn, td; bit ct, dok; logic [7:0] rs; logic ps, bz;
    run_main(8'd5, 8'd30, 2, 1'b1, st, bt, fc, ct, dok, dn, td, rs, ps, bz);
    n_checks++; if (st != 1) begin n_fail++; $display("FAIL ignore_start_cycles: got %0d want 1", st); end
    n_checks++; if (bt != 5 || count !== 8'd5) begin n_fail++; $display("FAIL ignore_beats: got %0d/%0d want 5/5", bt, count); end
    n_checks++; if (rs !== 8'd30 || ps !== 1'b1) begin n_fail++; $display("FAIL ignore_result: got %0d/%b want 30/1", rs, ps); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || start !== 1'b0) begin n_fail++; $display("FAIL ignore_report_go: got busy=%b start=%b want 0 0", busy, start); end
  endtask

  task automatic test_reset_mid;
    int st, bt, fc, dn, td; bit ct, dok, saw_done; logic [7:0] rs; logic ps, bz;
    go = 1'b1; cfg_count = 8'd5; expected = 8'd30;
    @(negedge clk);
    go = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL midrst_second_beat: got %b want 1", valid); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (outs_main !== '0) begin n_fail++; $display("FAIL midrst_outputs: got %h want 0", outs_main); end
    saw_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    n_checks++; if (saw_done) begin n_fail++; $display("FAIL midrst_no_done: got %b want 0", saw_done); end
    run_main(8'd5, 8'd30, -1, 1'b0, st, bt, fc, ct, dok, dn, td, rs, ps, bz);
    n_checks++;
    if (bt != 5 || dn != 1 || rs !== 8'd30 || ps !== 1'b1) begin
      n_fail++; $display("FAIL midrst_recovery: got beats=%0d done=%0d r=%0d p=%b want 5 1 30 1", bt, dn, rs, ps);
    end
  endtask

  task automatic test_watchdog;
    int st, bt, fc, dn, td; bit ct, dok; logic [7:0] rs; logic ps, bz;
    core_en = 1'b0; man_fin_at = -1;
    run_main(8'd0, 8'd0, -1, 1'b0, st, bt, fc, ct, dok, dn, td, rs, ps, bz);
`ifdef RANK_DRV_TIMEOUT_EN
    n_checks++; if (td != 9) begin n_fail++; $display("FAIL wd_done_cycle: got %0d want 9", td); end
    n_checks++; if (rs !== 8'd0 || ps !== 1'b0) begin n_fail++; $display("FAIL wd_result: got %0d/%b want 0/0", rs, ps); end
    n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL wd_timeout_flag: got %b want 1", timeout); end
    core_en = 1'b1;
    run_main(8'd5, 8'd30, -1, 1'b0, st, bt, fc, ct, dok, dn, td, rs, ps, bz);
    n_checks++; if (timeout !== 1'b0 || ps !== 1'b1) begin n_fail++; $display("FAIL wd_cleared_on_go: got %b/%b want 0/1", timeout, ps); end
`else
    n_checks++; if (dn != 0) begin n_fail++; $display("FAIL wait_persists: got %0d dones want 0", dn); end
    n_checks++; if (timeout !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL wait_flags: got t=%b busy=%b want 0 1", timeout, busy); end
    tl_man = 8'h33; finish_man = 1'b1;
    @(negedge clk);
    finish_man = 1'b0;
    n_checks++; if (done !== 1'b1 || result !== 8'h33) begin n_fail++; $display("FAIL wait_late_finish: got %b/%h want 1/33", done, result); end
    @(negedge clk);
    core_en = 1'b1;
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'(i), 8'(i), 4'h0};
    mem[0] = {8'd4, 8'd6, 4'h0};
    mem[1] = {8'd15, 8'd25, 4'h0};
    mem[2] = {8'd8, 8'd12, 4'h0};
    mem[3] = {8'd1, 8'd29, 4'h0};
    mem[4] = {8'd20, 8'd30, 4'h0};
    for (int i = 0; i < 4; i++) mem_g[i] = {8'(16 * i + 1), 8'(100 + i), 4'(i + 3)};
    test_reset;
    test_basic;
    test_mismatch;
    test_zero_count;
    test_gap;
    test_go_ignored;
    test_reset_mid;
    test_watchdog;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
